// File: rtl/flash_stream_reader_if.sv
// flash_stream_reader_if: flash read-master handshake plus the outgoing word stream
interface flash_stream_reader_if;
  logic        fl_inited;
  logic        fl_addr_en;
  logic [23:0] fl_addr_data;
  logic        fl_rd_data_available;
  logic [31:0] fl_rd_data;
  logic        fl_rd_ack;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  modport master(
    input  fl_inited, fl_rd_data_available, fl_rd_data, out_ready,
    output fl_addr_en, fl_addr_data, fl_rd_ack, out_valid, out_data, out_last
  );
  modport slave(
    output fl_inited, fl_rd_data_available, fl_rd_data, out_ready,
    input  fl_addr_en, fl_addr_data, fl_rd_ack, out_valid, out_data, out_last
  );
endinterface

// File: rtl/flash_stream_reader.sv
// flash_stream_reader: block read -> single-word flash requests -> FIFO stream; FLASH_RD_BSWAP_EN byte-reverses words
module flash_stream_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [23:0]       start_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  flash_stream_reader_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0] IDLE = 3'd0, WAIT_INIT = 3'd1, REQ = 3'd2, WAIT_DATA = 3'd3,
                         WAIT_DROP = 3'd4, FINISH = 3'd5, DISCARD = 3'd6;
  logic [2:0]            state;
  logic [23:0]           cur_addr;
  logic [CNT_W-1:0]      remaining;
  logic                  zero_req, last_taken, ack;
  logic [31:0]           mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_l;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           cnt;
  logic                  push, pop, last_pop, fin_zero;
  logic [31:0]           din;
`ifdef FLASH_RD_BSWAP_EN
  assign din = {bus.fl_rd_data[7:0], bus.fl_rd_data[15:8], bus.fl_rd_data[23:16], bus.fl_rd_data[31:24]};
`else
  assign din = bus.fl_rd_data;
`endif
  assign push = state == WAIT_DATA && bus.fl_rd_data_available;
  assign pop = bus.out_valid && bus.out_ready;
  assign last_pop = pop && bus.out_last;
  assign fin_zero = state == FINISH && zero_req;
  assign bus.out_valid = cnt != '0;
  assign bus.out_data = bus.out_valid ? mem_d[rd_ptr] : 32'h0;
  assign bus.out_last = bus.out_valid && mem_l[rd_ptr];
  assign bus.fl_addr_en = state == REQ;
  assign bus.fl_addr_data = cur_addr;
  assign bus.fl_rd_ack = ack;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
      zero_req <= 1'b0;
      last_taken <= 1'b0;
      ack <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      ack <= 1'b0;
      done <= last_pop || fin_zero;
      if (last_pop || fin_zero) busy <= 1'b0;
      if (last_pop) last_taken <= 1'b1;
      if (push) begin
        mem_d[wr_ptr] <= din;
        mem_l[wr_ptr] <= remaining == CNT_W'(1);
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        IDLE:
          // a word left behind in the master by a reset is acked and thrown away first
          if (bus.fl_rd_data_available) begin
            ack <= 1'b1;
            state <= DISCARD;
          end else if (start) begin
            cur_addr <= start_addr;
            remaining <= word_count;
            busy <= 1'b1;
            zero_req <= word_count == '0;
            last_taken <= 1'b0;
            state <= word_count == '0 ? FINISH : WAIT_INIT;
          end
        DISCARD: if (!bus.fl_rd_data_available) state <= IDLE;
        WAIT_INIT: if (bus.fl_inited && cnt < FULL) state <= REQ;
        REQ: state <= WAIT_DATA;
        WAIT_DATA:
          if (bus.fl_rd_data_available) begin
            ack <= 1'b1;
            cur_addr <= cur_addr + 24'd4;
            remaining <= remaining - CNT_W'(1);
            state <= WAIT_DROP;
          end
        WAIT_DROP: if (!bus.fl_rd_data_available) state <= remaining == '0 ? FINISH : WAIT_INIT;
        FINISH: if (zero_req || last_taken || last_pop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_stream_reader.sv
// tb_flash_stream_reader: table of block reads plus corner sequences, checked against a word/address scoreboard
module tb_flash_stream_reader;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [23:0] start_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done;
  flash_stream_reader_if bus();
  flash_stream_reader #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done), .bus(bus.master)
  );
  initial forever #5 clk = ~clk;

  typedef struct packed {logic [31:0] d; logic l;} exp_t;
  typedef struct {logic [23:0] sa; int n; bit rnd; int exp_en;} vec_t;
  exp_t        sq[$];
  logic [23:0] aq[$];
  vec_t        tbl[5];
  exp_t        e;
  int vecs = 0, bad = 0, cyc = 0, en_cnt = 0, ack_cnt = 0, done_cnt = 0, valid_cnt = 0;
  int done_cyc = 0, last_cyc = -10, lat = 0, mdl_left = -1;
  int e0, d0, a0, v0, k;
  bit rnd_rdy = 0, rdy_val = 1, man_req = 0, prev_stall = 0;
  logic [23:0] pend_addr = '0;
  logic [31:0] prev_d = '0;
  logic        prev_l = 1'b0;

  function automatic logic [31:0] fdat(input logic [23:0] a);
    return a == 24'h000040 ? 32'h11223344 : {~a[7:0], a};
  endfunction
  function automatic logic [31:0] xform(input logic [31:0] d);
`ifdef FLASH_RD_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // flash master model, stream sink and scoreboard, all evaluated on the falling edge
  initial begin
    bus.fl_rd_data_available = 1'b0;
    bus.fl_rd_data = '0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      bus.out_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : rdy_val;
      if (bus.fl_rd_ack) begin
        bus.fl_rd_data_available = 1'b0;
        ack_cnt++;
      end
      if (man_req) begin
        bus.fl_rd_data = 32'hDEADBEEF;
        bus.fl_rd_data_available = 1'b1;
        man_req = 0;
      end
      if (bus.fl_addr_en) begin
        en_cnt++;
        if (aq.size() == 0) begin
          vecs++; bad++;
          $display("FAIL addr_unexpected: got request at %h, want none", bus.fl_addr_data);
        end else chk("fl_addr_data", {8'h0, bus.fl_addr_data}, {8'h0, aq.pop_front()});
        if (mdl_left != 0) begin
          pend_addr = bus.fl_addr_data;
          lat = 1 + int'($urandom_range(0, 3));
          if (mdl_left > 0) mdl_left--;
        end
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          bus.fl_rd_data = fdat(pend_addr);
          bus.fl_rd_data_available = 1'b1;
        end
      end
      if (bus.out_valid) valid_cnt++;
      if (prev_stall && bus.out_valid) begin
        chk("hold_data", bus.out_data, prev_d);
        chk("hold_last", {31'h0, bus.out_last}, {31'h0, prev_l});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sq.size() == 0) begin
          vecs++; bad++;
          $display("FAIL stream_extra: got %h, want no word", bus.out_data);
        end else begin
          e = sq.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("out_last", {31'h0, bus.out_last}, {31'h0, e.l});
          if (e.l) last_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d = bus.out_data;
      prev_l = bus.out_last;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic push_exp(input logic [23:0] sa, input int n);
    for (int i = 0; i < n; i++) begin
      logic [23:0] a;
      a = sa + 24'(4 * i);
      aq.push_back(a);
      sq.push_back('{d: xform(fdat(a)), l: i == n - 1});
    end
  endtask
  task automatic pulse_start(input logic [23:0] sa, input int n);
    start_addr = sa;
    word_count = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input int base, input string nm);
    int w = 0;
    while (done_cnt == base && w < 3000) begin
      tick();
      w++;
    end
    if (done_cnt == base) begin
      vecs++; bad++;
      $display("FAIL %s: got no done after %0d cycles, want one", nm, w);
    end
  endtask
  task automatic run_block(input vec_t v);
    int be = en_cnt, bd = done_cnt;
    rnd_rdy = v.rnd;
    rdy_val = 1;
    push_exp(v.sa, v.n);
    pulse_start(v.sa, v.n);
    chk("busy_after_start", {31'h0, busy}, 32'h1);
    wait_done(bd, "done_timeout");
    chk("busy_at_done", {31'h0, busy}, 32'h0);
    chk("done_after_last", done_cyc, last_cyc + 1);
    tick(4);
    rnd_rdy = 0;
    chk("done_pulses", done_cnt - bd, 1);
    chk("addr_en_count", en_cnt - be, v.exp_en);
    chk("words_left", sq.size(), 0);
  endtask

  initial begin
    bus.fl_inited = 1'b1;
    tbl[0] = '{24'h100000, 3, 0, 3};
    tbl[1] = '{24'hFFFFF8, 3, 0, 3};
    tbl[2] = '{24'h000040, 1, 0, 1};
    tbl[3] = '{24'h0ABCD0, 6, 1, 6};
    tbl[4] = '{24'hFFFFF0, 9, 1, 9};
    tick(3);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_addr_en", {31'h0, bus.fl_addr_en}, 32'h0);
    chk("rst_addr_data", {8'h0, bus.fl_addr_data}, 32'h0);
    chk("rst_rd_ack", {31'h0, bus.fl_rd_ack}, 32'h0);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_last", {31'h0, bus.out_last}, 32'h0);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 5; i++) run_block(tbl[i]);

    e0 = en_cnt; d0 = done_cnt;
    pulse_start(24'h123456, 0);
    chk("zero_busy", {31'h0, busy}, 32'h1);
    chk("zero_done_early", {31'h0, done}, 32'h0);
    tick();
    chk("zero_done", {31'h0, done}, 32'h1);
    chk("zero_busy_end", {31'h0, busy}, 32'h0);
    tick(3);
    chk("zero_addr_en", en_cnt - e0, 0);
    chk("zero_done_count", done_cnt - d0, 1);

    e0 = en_cnt; d0 = done_cnt; rdy_val = 0;
    push_exp(24'h200000, 8);
    pulse_start(24'h200000, 8);
    tick(80);
    chk("stall_addr_en", en_cnt - e0, 4);
    chk("stall_valid", {31'h0, bus.out_valid}, 32'h1);
    rdy_val = 1;
    wait_done(d0, "stall_done_timeout");
    tick(2);
    chk("stall_total_en", en_cnt - e0, 8);
    chk("stall_words_left", sq.size(), 0);

    bus.fl_inited = 1'b0;
    e0 = en_cnt; d0 = done_cnt;
    push_exp(24'h300000, 2);
    pulse_start(24'h300000, 2);
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin
        start_addr = 24'h777777;
        word_count = 16'd5;
        start = 1'b1;
      end else start = 1'b0;
      tick();
    end
    start = 1'b0;
    chk("inited_hold_en", en_cnt - e0, 0);
    chk("inited_busy", {31'h0, busy}, 32'h1);
    bus.fl_inited = 1'b1;
    wait_done(d0, "inited_done_timeout");
    tick(20);
    chk("inited_en", en_cnt - e0, 2);
    chk("inited_words_left", sq.size(), 0);
    chk("inited_done_count", done_cnt - d0, 1);

    e0 = en_cnt; rdy_val = 0; mdl_left = 1;
    push_exp(24'h400000, 3);
    pulse_start(24'h400000, 3);
    k = 0;
    while (en_cnt - e0 < 2 && k < 500) begin
      tick();
      k++;
    end
    chk("rst_reached_wait_data", en_cnt - e0, 2);
    tick(2);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    sq.delete();
    aq.delete();
    rdy_val = 1;
    a0 = ack_cnt; v0 = valid_cnt;
    chk("rst_flush_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    man_req = 1;
    tick(10);
    chk("rst_discard_ack", ack_cnt - a0, 1);
    chk("rst_no_valid", valid_cnt - v0, 0);
    mdl_left = -1;
    run_block('{24'h500000, 4, 1, 4});

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule

// File: doc/flash_stream_reader.md
Name: flash_stream_reader

Overview:
- Upstream sequencer for the SPI flash read master: turns a block-read request (start address, word count) into single-word read transactions on the master's addr/ack handshake.
- Buffers returned 32-bit words in a small FIFO and presents them as a valid/ready stream, with a last-word marker, to the consumer (loader, pattern ROM, SoC boot copy).
- Handles back-pressure so that no word returned by the master is ever dropped.

Parameters:
- FIFO_DEPTH, 4, stream buffer entries; power of two, 2..16.
- CNT_W, 16, width of word_count and the internal remaining-word counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- start_addr  in  24  byte address of first word
- word_count  in  CNT_W  number of 32-bit words to read
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when last word leaves the stream
- fl_inited  in  1  flash master ready for requests
- fl_addr_en  out  1  one-cycle address strobe to master
- fl_addr_data  out  24  read address to master
- fl_rd_data_available  in  1  master holds a word
- fl_rd_data  in  32  word from master, first flash byte in [31:24]
- fl_rd_ack  out  1  one-cycle acknowledge to master
- out_valid  out  1  stream word valid
- out_data  out  32  stream word
- out_last  out  1  qualifies final word of the block
- out_ready  in  1  consumer accepts when out_valid & out_ready

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, address and counter registers 0.
- The master's addr_buffer_free is not used. Request pacing relies only on fl_inited and fl_rd_data_available.
- States and transitions:
  - IDLE: start=1 latches start_addr/word_count and sets busy=1.
    - word_count=0: go to FINISH, issuing no flash traffic.
    - Otherwise: go to WAIT_INIT.
    - start while busy is ignored.
  - WAIT_INIT: when fl_inited=1 and FIFO has a free slot, go to REQ.
  - REQ: drive fl_addr_data=cur_addr and fl_addr_en=1 for exactly one cycle, then go to WAIT_DATA.
  - WAIT_DATA: on fl_rd_data_available=1, push fl_rd_data into the FIFO.
    - out_last is tagged when remaining=1.
    - Pulse fl_rd_ack for one cycle, advance cur_addr by 4, decrement remaining, go to WAIT_DROP.
  - WAIT_DROP: wait for fl_rd_data_available=0.
    - remaining=0: go to FINISH.
    - Otherwise: go to WAIT_INIT.
  - FINISH: wait until the FIFO is empty and the last word (or none, for count 0) has been accepted.
    - Pulse done, clear busy, go to IDLE.
- Address arithmetic: 24-bit, wraps from 0xFFFFFC to 0x000000 without error.
- Back-pressure: a request is issued only while FIFO occupancy is below FIFO_DEPTH, so the single outstanding word always has a slot.
- FIFO timing:
  - A push in cycle N makes out_valid=1 in cycle N+1.
  - A simultaneous push and pop on a full FIFO is not possible by construction.
  - A simultaneous push and pop otherwise keeps the count unchanged.
- out_data/out_last are held stable while out_valid=1 and out_ready=0.
- For count>0, done asserts in the cycle after the handshake of the word carrying out_last.
- Reset mid-operation:
  - The FIFO is flushed and the state machine returns to IDLE; the master itself may still hold a word.
  - In IDLE, if fl_rd_data_available=1, the block pulses fl_rd_ack once, discards the data, and waits for it to drop before accepting start.

Optional Feature:
- Macro FLASH_RD_BSWAP_EN.
- Defined: out_data is byte-reversed relative to fl_rd_data. The first flash byte appears in [7:0], i.e. a little-endian word for RISC-V boot copy.
- Undefined: out_data equals fl_rd_data, with the first flash byte in [31:24].

Test Plan:
- start_addr=0x100000, word_count=3, out_ready=1, model returns addr-derived data -> fl_addr_data 0x100000, 0x100004, 0x100008; three words out; out_last only on the third; one done pulse; busy low after.
- word_count=0 -> no fl_addr_en, done pulses 2 cycles after start, busy high for exactly those cycles.
- out_ready=0, word_count=8, FIFO_DEPTH=4 -> exactly 4 fl_addr_en pulses, then stall; raising out_ready completes all 8 words in order with none lost.
- start_addr=0xFFFFF8, word_count=3 -> addresses 0xFFFFF8, 0xFFFFFC, 0x000000.
- fl_inited held 0 for 50 cycles after start -> no fl_addr_en until fl_inited=1; start pulsed again while busy is ignored.
- Reset asserted in WAIT_DATA; model then raises fl_rd_data_available -> one fl_rd_ack, no out_valid; a subsequent start runs normally.
- With FLASH_RD_BSWAP_EN: fl_rd_data=0x11223344 -> out_data=0x44332211.
